// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared 640x480@60 timing constants, frame-buffer geometry and
//               pixel type for the VGA frame-buffer reader.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam int IMG_W     = 320;
  localparam int IMG_H     = 240;
  localparam int ADDR_W    = 17;

  // Wide enough for both the 0..799 and 0..524 scan counters
  localparam int CNT_W     = 10;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Horizontal/vertical scan counters (stage 0) plus the
//               registered stage-1 decode of visible area, syncs and
//               frame start.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FP      = vga_pkg::H_FP,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BP      = vga_pkg::H_BP,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FP      = vga_pkg::V_FP,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BP      = vga_pkg::V_BP
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic [vga_pkg::CNT_W-1:0] h_cnt,
  output logic [vga_pkg::CNT_W-1:0] v_cnt,
  output logic                      active,
  output logic                      de1,
  output logic                      hs1_on,
  output logic                      vs1_on,
  output logic                      fs1
);
  import vga_pkg::*;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_VIS   = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS   = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_VISIBLE + H_FP);
  localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_VISIBLE + V_FP);
  localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_VISIBLE + V_FP + V_SYNC);

  // Current scan position lies inside the visible window
  assign active = (h_cnt < H_VIS) && (v_cnt < V_VIS);

  // Raster scan counters: pixel counter wraps each line, line counter each frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Stage-1 decode; syncs kept active-high here so a cleared pipeline is idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de1    <= 1'b0;
      hs1_on <= 1'b0;
      vs1_on <= 1'b0;
      fs1    <= 1'b0;
    end else begin
      de1    <= active;
      hs1_on <= (h_cnt >= HS_BEG) && (h_cnt < HS_END);
      vs1_on <= (v_cnt >= VS_BEG) && (v_cnt < VS_END);
      fs1    <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_fb_reader.sv
`default_nettype none
// ============================================================================
// Module      : vga_fb_reader
// Description : Frame-buffer read master for 640x480 VGA, 2x upscaling of a
//               320x240 RGB565 image, registered RGB444 + sync outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_fb_reader #(
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FP      = vga_pkg::H_FP,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BP      = vga_pkg::H_BP,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FP      = vga_pkg::V_FP,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BP      = vga_pkg::V_BP,
  parameter int IMG_W     = vga_pkg::IMG_W,
  parameter int ADDR_W    = vga_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  output logic              oe,
  output logic [ADDR_W-1:0] rAddr,
  input  logic [15:0]       rData,
  output logic              h_sync,
  output logic              v_sync,
  output logic              de,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              frame_start
);
  import vga_pkg::*;

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] V_VIS_END = CNT_W'(V_VISIBLE - 1);

  logic [CNT_W-1:0]  h_cnt;
  logic [CNT_W-1:0]  v_cnt;
  logic              active;
  logic              de1, hs1_on, vs1_on, fs1;
  logic              de2, hs2_on, vs2_on, fs2;
  logic [ADDR_W-1:0] row_base;
  rgb565_t           px;

  vga_timing_gen #(
    .H_VISIBLE (H_VISIBLE),
    .H_FP      (H_FP),
    .H_SYNC    (H_SYNC),
    .H_BP      (H_BP),
    .V_VISIBLE (V_VISIBLE),
    .V_FP      (V_FP),
    .V_SYNC    (V_SYNC),
    .V_BP      (V_BP)
  ) u_timing (
    .clk    (clk),
    .reset  (reset),
    .h_cnt  (h_cnt),
    .v_cnt  (v_cnt),
    .active (active),
    .de1    (de1),
    .hs1_on (hs1_on),
    .vs1_on (vs1_on),
    .fs1    (fs1)
  );

  // The read strobe is exactly the stage-1 visible flag
  assign oe = de1;

  // Address generation: row base steps by one image row after every odd line,
  // so each stored row is fetched for two screen lines; h_cnt>>1 doubles columns
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rAddr    <= '0;
      row_base <= '0;
    end else begin
      if (active) begin
        rAddr <= row_base + ADDR_W'(h_cnt >> 1);
      end
      if (h_cnt == H_LAST) begin
        if (v_cnt == V_LAST) begin
          row_base <= '0;
        end else if (v_cnt[0] && (v_cnt < V_VIS_END)) begin
          row_base <= row_base + ADDR_W'(IMG_W);
        end
      end
    end
  end

  // Stage 2: pure delay covering the frame buffer's one-cycle read latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de2    <= 1'b0;
      hs2_on <= 1'b0;
      vs2_on <= 1'b0;
      fs2    <= 1'b0;
    end else begin
      de2    <= de1;
      hs2_on <= hs1_on;
      vs2_on <= vs1_on;
      fs2    <= fs1;
    end
  end

  assign px = rgb565_t'(rData);

  // Stage 3: registered outputs; colour blanked outside the visible area
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_sync      <= 1'b1;
      v_sync      <= 1'b1;
      de          <= 1'b0;
      frame_start <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
    end else begin
      h_sync      <= ~hs2_on;
      v_sync      <= ~vs2_on;
      de          <= de2;
      frame_start <= fs2;
      red         <= de2 ? px.r[4:1] : 4'h0;
      green       <= de2 ? px.g[5:2] : 4'h0;
      blue        <= de2 ? px.b[4:1] : 4'h0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_fb_reader
// Description : Self-checking bench for vga_fb_reader using a reduced raster
//               and a position-based reference model of the expected outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_fb_reader;

  localparam int HV = 64, HFP = 4, HS = 8, HBP = 4;
  localparam int VV = 48, VFP = 2, VS = 2, VBP = 3;
  localparam int HT = HV + HFP + HS + HBP;
  localparam int VT = VV + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int IMG_W = HV / 2;
  localparam int ADDR_W = 17;
  localparam int MAX_ADDR = (VV / 2 - 1) * IMG_W + IMG_W - 1;
  localparam int RED_ADDR = IMG_W + 5;

  logic              clk;
  logic              reset;
  logic              oe;
  logic [ADDR_W-1:0] raddr;
  logic [15:0]       rdata;
  logic              h_sync, v_sync, de, frame_start;
  logic [3:0]        red, green, blue;

  logic [15:0] mem [0:1023];

  int checks = 0;
  int errors = 0;
  int k;
  int exp_addr;
  int phase;
  int fs_cnt, de_cnt, hs_low, vs_low, max_addr;

  vga_fb_reader #(
    .H_VISIBLE (HV), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
    .V_VISIBLE (VV), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
    .IMG_W (IMG_W), .ADDR_W (ADDR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .oe          (oe),
    .rAddr       (raddr),
    .rData       (rdata),
    .h_sync      (h_sync),
    .v_sync      (v_sync),
    .de          (de),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame buffer read port: synchronous read, garbage (all ones) when idle
  always @(posedge clk) begin
    rdata <= oe ? mem[raddr[9:0]] : 16'hFFFF;
  end

  function automatic logic [15:0] out_vec();
    return {h_sync, v_sync, de, frame_start, red, green, blue};
  endfunction

  // Advance one clock, predict outputs from raster position, compare at negedge
  task automatic step();
    int q, hq, vq, p, h, v, a;
    logic e_oe, e_hs, e_vs, e_de, e_fs;
    logic [15:0] d, e_out;
    @(posedge clk);
    k++;
    q  = k - 1;
    hq = q % HT;
    vq = (q / HT) % VT;
    e_oe = (hq < HV) && (vq < VV);
    if (e_oe) exp_addr = (vq / 2) * IMG_W + hq / 2;
    if (k < 3) begin
      e_out = 16'hC000;
    end else begin
      p    = k - 3;
      h    = p % HT;
      v    = (p / HT) % VT;
      e_de = (h < HV) && (v < VV);
      e_hs = !((h >= HV + HFP) && (h < HV + HFP + HS));
      e_vs = !((v >= VV + VFP) && (v < VV + VFP + VS));
      e_fs = (h == 0) && (v == 0);
      a    = (v / 2) * IMG_W + h / 2;
      d    = e_de ? mem[a] : 16'h0000;
      e_out = {e_hs, e_vs, e_de, e_fs, d[15:12], d[10:7], d[4:1]};
    end
    @(negedge clk);
    checks++;
    assert ({oe, raddr} === {e_oe, ADDR_W'(exp_addr)}) else begin
      errors++;
      $error("FAIL read_port k=%0d obs oe=%b addr=%0d exp oe=%b addr=%0d",
             k, oe, raddr, e_oe, exp_addr);
    end
    checks++;
    assert (out_vec() === e_out) else begin
      errors++;
      $error("FAIL video_out k=%0d obs=%h exp=%h", k, out_vec(), e_out);
    end
    if (phase == 1 && k >= 3 && k < 3 + FRAME) begin
      if (frame_start) fs_cnt++;
      if (de) de_cnt++;
      if (!h_sync) hs_low++;
      if (!v_sync) vs_low++;
    end
    if (phase == 1 && k >= 1 && k < 1 + FRAME && oe && int'(raddr) > max_addr)
      max_addr = int'(raddr);
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    mem[RED_ADDR] = 16'hF800;
    k = 0; exp_addr = 0; phase = 1;
    fs_cnt = 0; de_cnt = 0; hs_low = 0; vs_low = 0; max_addr = 0;
    repeat (3) @(negedge clk);

    checks++;
    assert ({out_vec(), oe, raddr} === {16'hC000, 1'b0, 17'd0}) else begin
      errors++;
      $error("FAIL reset_state obs=%h oe=%b addr=%0d exp=c000 oe=0 addr=0",
             out_vec(), oe, raddr);
    end

    reset = 1'b0;
    step();
    checks++;
    assert ({oe, raddr} === {1'b1, 17'd0}) else begin
      errors++;
      $error("FAIL first_read obs oe=%b addr=%0d exp oe=1 addr=0", oe, raddr);
    end
    for (int i = 1; i < 2 * FRAME + 20 * HT + 30; i++) step();

    checks++;
    assert (fs_cnt === 1) else begin
      errors++; $error("FAIL frame_start_count obs=%0d exp=1", fs_cnt);
    end
    checks++;
    assert (de_cnt === HV * VV) else begin
      errors++; $error("FAIL de_count obs=%0d exp=%0d", de_cnt, HV * VV);
    end
    checks++;
    assert (hs_low === HS * VT) else begin
      errors++; $error("FAIL hsync_low obs=%0d exp=%0d", hs_low, HS * VT);
    end
    checks++;
    assert (vs_low === VS * HT) else begin
      errors++; $error("FAIL vsync_low obs=%0d exp=%0d", vs_low, VS * HT);
    end
    checks++;
    assert (max_addr === MAX_ADDR) else begin
      errors++; $error("FAIL max_addr obs=%0d exp=%0d", max_addr, MAX_ADDR);
    end

    // Mid-frame reset: outputs must return to idle without waiting for a clock
    reset = 1'b1;
    #1;
    checks++;
    assert ({out_vec(), oe, raddr} === {16'hC000, 1'b0, 17'd0}) else begin
      errors++;
      $error("FAIL async_reset obs=%h oe=%b addr=%0d exp=c000 oe=0 addr=0",
             out_vec(), oe, raddr);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    assert ({out_vec(), oe, raddr} === {16'hC000, 1'b0, 17'd0}) else begin
      errors++;
      $error("FAIL held_reset obs=%h oe=%b addr=%0d exp=c000 oe=0 addr=0",
             out_vec(), oe, raddr);
    end

    reset = 1'b0;
    k = 0; exp_addr = 0; phase = 2;
    for (int i = 0; i < 3; i++) step();
    checks++;
    assert (frame_start === 1'b1) else begin
      errors++; $error("FAIL restart_frame_start obs=%b exp=1", frame_start);
    end
    for (int i = 3; i < FRAME + 2 * HT; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_fb_reader.md
Name: vga_fb_reader

Overview:
- Read-side master for the 320x240 RGB565 dual-port frame buffer. Drives the buffer's read port (oe, rAddr, rData) from its own 640x480@60 VGA timing.
- Upscales 2x in both axes: each stored pixel covers 2x2 screen pixels.
- Outputs registered, pipeline-aligned h_sync/v_sync/de and RGB444 to the VGA DAC. Sits between the frame buffer and the board's VGA connector, clocked at the 25 MHz pixel clock, which is also the buffer's rclk.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync width
H_BP, 48, horizontal back porch
V_VISIBLE, 480, active lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync width
V_BP, 33, vertical back porch
IMG_W, 320, stored image width
ADDR_W, 17, frame buffer address width

Ports:
clk  input  1  pixel clock (25 MHz); also frame buffer rclk
reset  input  1  asynchronous, active-high reset
oe  output  1  frame buffer read enable
rAddr  output  ADDR_W  frame buffer read address
rData  input  16  frame buffer read data, RGB565, valid one clk after oe/rAddr
h_sync  output  1  horizontal sync, active-low
v_sync  output  1  vertical sync, active-low
de  output  1  display enable, high in visible area
red  output  4  rData[15:12] when de, else 0
green  output  4  rData[10:7] when de, else 0
blue  output  4  rData[4:1] when de, else 0
frame_start  output  1  one-cycle pulse aligned with the first visible pixel (0,0) at the outputs

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset values: h_sync=1, v_sync=1, de=0, red/green/blue=0, oe=0, rAddr=0, frame_start=0. All counters and pipeline registers also clear to 0.
- h_cnt runs 0..799 and v_cnt runs 0..524.
  - h_cnt wraps at H_TOTAL-1 = 799.
  - v_cnt increments when h_cnt wraps, and wraps at 524.
- Stage 0 is the counters, evaluated in cycle n.
- Stage 1 registers at edge n+1:
  - vis = (h_cnt<640)&&(v_cnt<480).
  - oe = vis.
  - rAddr = row_base + (h_cnt>>1) when vis, else holds its previous value.
  - hs1 = !(656<=h_cnt<752).
  - vs1 = !(490<=v_cnt<492).
  - de1 = vis.
  - fs1 = (h_cnt==0 && v_cnt==0).
- Stage 2 is a delay-only stage that matches the buffer's one-cycle read latency: hs2, vs2, de2, fs2.
- Stage 3 drives the outputs, registered from rData and the stage-2 signals. Total latency from counters to outputs is 3 clk.
- Address generation uses no multiplier.
  - row_base is an ADDR_W-bit register.
  - At h_cnt==799: if v_cnt is odd and v_cnt<479, then row_base += IMG_W.
  - At h_cnt==799 and v_cnt==524, row_base clears to 0.
  - Otherwise row_base holds.
  - Maximum rAddr = 239*320+319 = 76799, which fits in 17 bits. No wrap occurs inside a frame.
- Blanking: when de would be 0, red/green/blue are forced to 0 regardless of rData. oe is low throughout blanking.
- Reset mid-frame: all outputs return to reset values asynchronously. After release, scanning restarts at (0,0) with row_base=0. The first frame_start occurs 3 clk after release.
- There is no handshake back-pressure. The frame buffer must return data every cycle oe is high. The write side is independent; tearing is acceptable.

Decomposition:
- Shared package vga_pkg:
  - timing constants H_VISIBLE..V_BP, H_TOTAL=800, V_TOTAL=525
  - IMG_W=320, IMG_H=240
  - typedef rgb565_t as a packed struct {r[4:0], g[5:0], b[4:0]}
- One natural sub-module, vga_timing_gen, containing the h_cnt/v_cnt counters plus the stage-1 sync/de/vis decode. vga_fb_reader instantiates it and owns the address generation, delay alignment and RGB output stage.

Test Plan:
- Reset then run one full frame -> first rAddr=0 with oe=1 at cycle 1. frame_start pulses once per 420000 clk. Exactly 307200 de-high cycles per frame.
- Sample rAddr on lines 0, 1 and 2 at h_cnt 0..3 -> lines 0 and 1 give 0,0,1,1. Line 2 gives 320,320,321,321.
- Line 479, h_cnt=639 -> rAddr=76799. Next frame line 0 -> rAddr=0 again.
- Monitor syncs -> h_sync low for 96 clk starting 3 clk after h_cnt=656. v_sync low for exactly 2 lines (1600 clk) per frame.
- Model returns rData=16'hF800 for one address -> red=4'hF, green=0, blue=0 exactly 2 clk after that rAddr. rData=16'hFFFF during blanking -> outputs 0.
- Assert reset at v_cnt=200, h_cnt=300 for 2 clk -> outputs immediately at reset values. The next frame_start is 3 clk after release, with rAddr restarting at 0.
